// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the core's single memory port between instruction fetch (IF) and
//   data load/store (MEM). Requests are serialised onto one req/ack memory
//   interface. Data has priority. Per-requester stall outputs feed the
//   pipeline hazard logic. A pipeline flush discards an in-flight fetch.
//
//   Optional build macro STARVE_GUARD_EN: after MAX_DM_RUN consecutive data
//   grants made while a fetch waits, the next arbitration favours the fetch.
//
//   state        | meaning
//   -------------+---------------------------------------------
//   IDLE         | no transaction in flight
//   GNT_DM       | data transaction in flight
//   GNT_IF       | fetch transaction in flight
//   GNT_IF_DROP  | flushed fetch in flight, result discarded
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   flush                     pipeline flush (cancels current/pending fetch)
//   if_req/if_addr            fetch request (level) and address
//   if_rdata/if_valid/if_stall fetch data, completion pulse, waiting flag
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb  data request and fields
//   dm_rdata/dm_valid/dm_stall load data, completion pulse, waiting flag
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request side
//   mem_ack/mem_rdata         memory completion and read data
//   busy                      a transaction is in flight

module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_DM_RUN = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic [DATA_W-1:0]     if_rdata,
   output logic                  if_valid,
   output logic                  if_stall,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_W-1:0]     dm_addr,
   input  logic [DATA_W-1:0]     dm_wdata,
   input  logic [DATA_W/8-1:0]   dm_wstrb,
   output logic [DATA_W-1:0]     dm_rdata,
   output logic                  dm_valid,
   output logic                  dm_stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      GNT_DM      = 2'd1,
      GNT_IF      = 2'd2,
      GNT_IF_DROP = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [DATA_W/8-1:0]   mem_wstrb_q, mem_wstrb_d;
   logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]     dm_rdata_q, dm_rdata_d;
   logic                  if_valid_q, if_valid_d;
   logic                  dm_valid_q, dm_valid_d;
   logic                  busy_q, busy_d;

   logic                  dm_elig;
   logic                  if_elig;
   logic                  guard_hit;
   logic                  grant_dm;
   logic                  grant_if;

   if (MAX_DM_RUN < 1) begin : g_max_dm_run_check
      $error("MAX_DM_RUN must be at least 1");
   end

   // A requester whose completion pulse is visible this cycle is still
   // holding its old request; masking it avoids re-issuing the same access.
   assign dm_elig = dm_req & ~dm_valid_q;
   assign if_elig = if_req & ~if_valid_q & ~flush;

`ifdef STARVE_GUARD_EN
   localparam int RUN_W = $clog2(MAX_DM_RUN + 1);

   logic [RUN_W-1:0] run_q, run_d;

   assign guard_hit = (run_q >= RUN_W'(MAX_DM_RUN));

   // Counts data grants won while a fetch is waiting; saturates at the limit.
   always_comb begin
      run_d = run_q;
      if (!if_req || grant_if) begin
         run_d = '0;
      end else if (grant_dm && (run_q < RUN_W'(MAX_DM_RUN))) begin
         run_d = run_q + RUN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end
`else
   assign guard_hit = 1'b0;
`endif

   always_comb begin
      grant_dm = 1'b0;
      grant_if = 1'b0;
      if (state_q == IDLE) begin
         if (guard_hit && if_elig) begin
            grant_if = 1'b1;
         end else if (dm_elig) begin
            grant_dm = 1'b1;
         end else if (if_elig) begin
            grant_if = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // mem_ack is ignored here: a late ack from an abandoned access
            // must not complete anything.
            if (grant_dm) begin
               state_d     = GNT_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               mem_wstrb_d = dm_wstrb;
            end else if (grant_if) begin
               state_d     = GNT_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               mem_wstrb_d = '0;
            end
         end
         GNT_DM: begin
            if (mem_ack) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               dm_valid_d = 1'b1;
               if (!mem_we_q) begin
                  dm_rdata_d = mem_rdata;
               end
            end
         end
         GNT_IF: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               // A flush arriving with the ack still kills this fetch.
               if (!flush) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end else if (flush) begin
               state_d = GNT_IF_DROP;
            end
         end
         GNT_IF_DROP: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
   assign busy      = busy_q;

   assign if_stall  = if_req & ~if_valid_q;
   assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int K_IF = 0;
   localparam int K_LD = 1;
   localparam int K_ST = 2;
`ifdef STARVE_GUARD_EN
   localparam int EXP_DM_BEFORE_IF = 4;
`else
   localparam int EXP_DM_BEFORE_IF = 6;
`endif

   logic                clk;
   logic                rst;
   logic                flush;
   logic                if_req;
   logic [ADDR_W-1:0]   if_addr;
   logic [DATA_W-1:0]   if_rdata;
   logic                if_valid;
   logic                if_stall;
   logic                dm_req;
   logic                dm_we;
   logic [ADDR_W-1:0]   dm_addr;
   logic [DATA_W-1:0]   dm_wdata;
   logic [DATA_W/8-1:0] dm_wstrb;
   logic [DATA_W-1:0]   dm_rdata;
   logic                dm_valid;
   logic                dm_stall;
   logic                mem_req;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic                mem_ack;
   logic [DATA_W-1:0]   mem_rdata;
   logic                busy;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DM_RUN(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int overlap = 0;

   always @(negedge clk) begin
      if (if_valid && dm_valid) overlap++;
   end

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          ack_dly;
      logic [31:0] mem_rd;
      logic        exp_we;
      logic [3:0]  exp_wstrb;
      int          exp_lat;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl[6];
   vec_t tied[4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc_start();
      @(negedge clk);
      #1;
   endtask

   // One transaction from request to completion pulse. Memory acks on the
   // ack_dly-th cycle of mem_req, or every cycle when tie is set.
   task automatic do_txn(input vec_t v, input bit tie, input string nm);
      int          cyc;
      int          reqcnt;
      int          lat;
      bit          seen_req;
      bit          stall_ok;
      bit          other_ok;
      logic [31:0] cap_addr;
      logic        cap_we;
      logic [31:0] cap_wdata;
      logic [3:0]  cap_wstrb;
      logic        my_valid;
      logic        other_valid;
      logic        my_stall;
      cap_addr = 'x; cap_we = 'x; cap_wdata = 'x; cap_wstrb = 'x;
      cyc = 0; reqcnt = 0; lat = -1; seen_req = 0; stall_ok = 1; other_ok = 1;
      cyc_start();
      if (v.kind == K_IF) begin
         if_req = 1'b1; if_addr = v.addr;
      end else begin
         dm_req = 1'b1; dm_we = (v.kind == K_ST); dm_addr = v.addr;
         dm_wdata = v.wdata; dm_wstrb = v.wstrb;
      end
      mem_ack = tie;
      mem_rdata = v.mem_rd;
      #1;
      my_stall = (v.kind == K_IF) ? if_stall : dm_stall;
      if (my_stall !== 1'b1) stall_ok = 0;
      while (cyc < 40 && lat < 0) begin
         cyc_start();
         cyc++;
         my_valid    = (v.kind == K_IF) ? if_valid : dm_valid;
         other_valid = (v.kind == K_IF) ? dm_valid : if_valid;
         my_stall    = (v.kind == K_IF) ? if_stall : dm_stall;
         if (other_valid !== 1'b0) other_ok = 0;
         if (my_valid === 1'b1) begin
            lat = cyc;
            if (my_stall !== 1'b0) stall_ok = 0;
         end else if (my_stall !== 1'b1) begin
            stall_ok = 0;
         end
         if (mem_req === 1'b1) begin
            reqcnt++;
            if (!seen_req) begin
               seen_req = 1;
               cap_addr = mem_addr; cap_we = mem_we;
               cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
            end
         end
         mem_ack = tie || (mem_req && (reqcnt == v.ack_dly));
      end
      if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
      chk({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
      chk({nm, " mem_addr"}, {32'h0, cap_addr}, {32'h0, v.addr});
      chk({nm, " mem_we"}, {63'h0, cap_we}, {63'h0, v.exp_we});
      chk({nm, " mem_wstrb"}, {60'h0, cap_wstrb}, {60'h0, v.exp_wstrb});
      if (v.kind == K_ST) chk({nm, " mem_wdata"}, {32'h0, cap_wdata}, {32'h0, v.wdata});
      if (v.kind == K_IF) chk({nm, " if_rdata"}, {32'h0, if_rdata}, {32'h0, v.exp_rdata});
      else                chk({nm, " dm_rdata"}, {32'h0, dm_rdata}, {32'h0, v.exp_rdata});
      chk({nm, " stall"}, {63'h0, stall_ok}, 64'h1);
      chk({nm, " other valid"}, {63'h0, other_ok}, 64'h1);
   endtask

   initial begin
      int cyc;
      int dmcnt;
      int dm_before_if;
      bit if_done;
      vec_t v;

      //          kind  addr          wdata         strb  ack mem_rdata     we    strb  lat exp_rdata
      tbl[0] = '{K_IF, 32'h0000_0100, 32'h0,        4'h0, 2, 32'h0050_0093, 1'b0, 4'h0, 3, 32'h0050_0093};
      tbl[1] = '{K_LD, 32'h0000_2004, 32'h0,        4'hF, 1, 32'h1234_5678, 1'b0, 4'hF, 2, 32'h1234_5678};
      tbl[2] = '{K_ST, 32'h0000_2008, 32'hCAFE_F00D, 4'h3, 1, 32'hFFFF_FFFF, 1'b1, 4'h3, 2, 32'h1234_5678};
      tbl[3] = '{K_IF, 32'h0000_010C, 32'h0,        4'h0, 4, 32'h0000_0013, 1'b0, 4'h0, 5, 32'h0000_0013};
      tbl[4] = '{K_LD, 32'h0000_3000, 32'h0,        4'hF, 3, 32'hA5A5_5A5A, 1'b0, 4'hF, 4, 32'hA5A5_5A5A};
      tbl[5] = '{K_ST, 32'h0000_3004, 32'h0BAD_F00D, 4'hC, 2, 32'h1111_1111, 1'b1, 4'hC, 3, 32'hA5A5_5A5A};

      tied[0] = '{K_LD, 32'h0000_6000, 32'h0, 4'hF, 1, 32'h600D_0001, 1'b0, 4'hF, 2, 32'h600D_0001};
      tied[1] = '{K_IF, 32'h0000_0500, 32'h0, 4'h0, 1, 32'h0010_0073, 1'b0, 4'h0, 2, 32'h0010_0073};
      tied[2] = '{K_LD, 32'h0000_6004, 32'h0, 4'hF, 1, 32'h600D_0002, 1'b0, 4'hF, 2, 32'h600D_0002};
      tied[3] = '{K_IF, 32'h0000_0504, 32'h0, 4'h0, 1, 32'h0000_0013, 1'b0, 4'h0, 2, 32'h0000_0013};

      rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      cyc_start();
      chk("reset mem_req", {63'h0, mem_req}, 64'h0);
      chk("reset busy", {63'h0, busy}, 64'h0);
      chk("reset valids", {62'h0, if_valid, dm_valid}, 64'h0);
      chk("reset mem_addr", {32'h0, mem_addr}, 64'h0);
      chk("reset rdata", {if_rdata, dm_rdata}, 64'h0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) do_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));

      // Simultaneous store and fetch: data first, one idle cycle, then fetch.
      cyc_start();
      if_req = 1'b1; if_addr = 32'h104;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
      cyc_start();
      chk("sim first grant addr", {32'h0, mem_addr}, 64'h2000);
      chk("sim first grant we", {63'h0, mem_we}, 64'h1);
      chk("sim first grant wdata", {32'h0, mem_wdata}, 64'hDEAD_BEEF);
      chk("sim first grant wstrb", {60'h0, mem_wstrb}, 64'hF);
      chk("sim first grant req", {63'h0, mem_req}, 64'h1);
      mem_ack = 1'b1;
      cyc_start();
      chk("sim dm_valid", {62'h0, dm_valid, if_valid}, 64'h2);
      chk("sim gap mem_req", {63'h0, mem_req}, 64'h0);
      chk("sim stalls", {62'h0, if_stall, dm_stall}, 64'h2);
      dm_req = 1'b0; mem_ack = 1'b0;
      cyc_start();
      chk("sim fetch grant", {30'h0, mem_req, mem_we, mem_addr}, {30'h0, 2'b10, 32'h104});
      chk("sim fetch wstrb", {60'h0, mem_wstrb}, 64'h0);
      mem_ack = 1'b1; mem_rdata = 32'h00A0_0113;
      cyc_start();
      chk("sim if_valid", {62'h0, if_valid, dm_valid}, 64'h2);
      chk("sim if_rdata", {32'h0, if_rdata}, 64'h00A0_0113);
      if_req = 1'b0; mem_ack = 1'b0;

      // Flush one cycle into a fetch; the dropped fetch must not complete.
      cyc_start();
      if_req = 1'b1; if_addr = 32'h108;
      cyc_start();
      chk("flush grant addr", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h108});
      flush = 1'b1;
      cyc_start();
      chk("flush drop busy", {62'h0, mem_req, busy}, 64'h3);
      flush = 1'b0; if_addr = 32'h200;
      cyc_start();
      chk("flush drop addr stable", {32'h0, mem_addr}, 64'h108);
      chk("flush drop no valid", {63'h0, if_valid}, 64'h0);
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      cyc_start();
      chk("flush ack no valid", {63'h0, if_valid}, 64'h0);
      chk("flush ack idle", {62'h0, mem_req, busy}, 64'h0);
      chk("flush if_rdata kept", {32'h0, if_rdata}, 64'h00A0_0113);
      chk("flush if_stall", {63'h0, if_stall}, 64'h1);
      mem_ack = 1'b0;
      cyc_start();
      chk("flush next grant", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h200});
      chk("flush next no valid yet", {63'h0, if_valid}, 64'h0);
      mem_ack = 1'b1; mem_rdata = 32'h0000_0297;
      cyc_start();
      chk("flush next valid", {63'h0, if_valid}, 64'h1);
      chk("flush next rdata", {32'h0, if_rdata}, 64'h0000_0297);
      if_req = 1'b0; mem_ack = 1'b0;

      // Reset while a data access waits for its ack; a late ack is ignored.
      cyc_start();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000; dm_wstrb = 4'hF;
      cyc_start();
      chk("rst pre req", {63'h0, mem_req}, 64'h1);
      rst = 1'b1;
      cyc_start();
      chk("rst mid idle", {60'h0, mem_req, busy, if_valid, dm_valid}, 64'h0);
      chk("rst mid addr", {32'h0, mem_addr}, 64'h0);
      rst = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
      cyc_start();
      chk("rst stray ack", {61'h0, mem_req, busy, dm_valid}, 64'h0);
      chk("rst stray rdata", {32'h0, dm_rdata}, 64'h0);
      mem_ack = 1'b0;
      v = '{K_IF, 32'h300, 32'h0, 4'h0, 1, 32'h0000_0317, 1'b0, 4'h0, 2, 32'h0000_0317};
      do_txn(v, 1'b0, "post-rst fetch");

      for (int i = 0; i < 4; i++) do_txn(tied[i], 1'b1, $sformatf("tied%0d", i));

      // Fetch waiting behind a stream of six loads; flush is raised on each
      // load completion cycle so the fetch cannot slip into that idle slot.
      cyc_start();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h5000; dm_wstrb = 4'hF;
      if_req = 1'b1; if_addr = 32'h400; mem_ack = 1'b1; mem_rdata = 32'h77;
      cyc = 0; dmcnt = 0; dm_before_if = -1; if_done = 0;
      while (cyc < 80 && !(if_done && dmcnt == 6)) begin
         cyc_start();
         cyc++;
         if (dm_valid) dmcnt++;
         if (mem_req && mem_addr == 32'h400 && dm_before_if < 0) dm_before_if = dmcnt;
         if (if_valid) if_done = 1;
         flush = dm_valid;
         if (dmcnt == 6) dm_req = 1'b0;
         if (if_done) if_req = 1'b0;
      end
      flush = 1'b0; dm_req = 1'b0; if_req = 1'b0; mem_ack = 1'b0;
      chk("starve finished", {63'h0, (if_done && dmcnt == 6)}, 64'h1);
      chk("starve dm grants before fetch", 64'(dm_before_if), 64'(EXP_DM_BEFORE_IF));
      chk("starve if_rdata", {32'h0, if_rdata}, 64'h77);

      cyc_start();
      chk("valid overlap count", 64'(overlap), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between instruction fetch (IF stage) and data load/store (MEM stage) of the pipelined core.
- Serialises both requesters onto one request/acknowledge memory interface and drives per-requester stall outputs that feed the pipeline hazard/stall logic.
- Discards in-flight fetches on a pipeline flush (branch/jump redirect).

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- MAX_DM_RUN, 4, consecutive data grants allowed while a fetch waits. Used only with STARVE_GUARD_EN.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  pipeline flush; cancels the current or pending fetch.
- if_req  in  1  fetch request, level; held until if_valid.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  fetch waiting.
- dm_req  in  1  data request, level; held until dm_valid.
- dm_we  in  1  1 = store.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_wstrb  in  DATA_W/8  byte strobes.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  one-cycle data completion pulse.
- dm_stall  out  1  data access waiting.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory strobes.
- mem_ack  in  1  memory completion; may be combinational in the same cycle as mem_req.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- busy  out  1  a transaction is in flight.

Behaviour:
- Reset: applied synchronously on the clk edge with rst=1. All outputs go to 0, the FSM goes to IDLE, the drop flag clears and the run counter clears.
- FSM states:
  - IDLE: no transaction in flight.
  - GNT_DM: data transaction in flight.
  - GNT_IF: fetch transaction in flight.
  - GNT_IF_DROP: flushed fetch in flight; its result is discarded.
- IDLE arbitration:
  - Data has priority. dm_req → GNT_DM; else if_req && !flush → GNT_IF.
  - A requester whose valid pulse is high in the current cycle is masked for that cycle.
  - On a grant, the request fields are latched into the mem_* output registers.
  - IF grants force mem_we=0 and mem_wstrb=0.
- Grant states:
  - mem_req=1 for the whole state; busy=1.
  - On a cycle with mem_ack=1, next state is IDLE, mem_req=0 and the matching valid pulse is registered.
  - if_rdata and dm_rdata capture mem_rdata on that edge.
  - dm_rdata holds its previous value on store completion.
- Latency:
  - Request seen in IDLE at cycle 0; mem_req high from cycle 1; ack at cycle k≥1; valid at cycle k+1.
  - Minimum 2 cycles; back-to-back grants have one IDLE cycle between them.
- Flush:
  - In GNT_IF: next state is GNT_IF_DROP. On ack → IDLE, no if_valid, if_rdata unchanged.
  - In IDLE: suppresses an IF grant that cycle.
  - In GNT_DM: no effect.
  - In the same cycle as if_valid: if_valid is still asserted; the pipeline discards it.
- Stall outputs, combinational from registered state:
  - if_stall = if_req & ~if_valid.
  - dm_stall = dm_req & ~dm_valid.
- mem_* fields are stable while mem_req=1.
- Reset mid-transaction: mem_req drops on the reset edge. The memory abandons the access on mem_req deassert; any stray mem_ack while in IDLE is ignored.
- mem_ack outside a grant state is ignored.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- Defined:
  - A counter increments on each data grant made while if_req is pending.
  - On reaching MAX_DM_RUN, the next IDLE arbitration grants IF ahead of a pending dm_req.
  - The counter clears on any IF grant or when if_req is low.
- Undefined: strict data priority; counter logic is absent and MAX_DM_RUN is unused.

Test Plan:
- Single fetch: if_addr=0x100, mem_ack two cycles after mem_req rises, mem_rdata=0x00500093 → mem_addr=0x100, mem_we=0, if_valid pulses once at cycle 3, if_rdata=0x00500093, if_stall high cycles 0–2.
- Simultaneous if_req (0x104) and dm_req store (0x2000, 0xDEADBEEF, strb 0xF) → first grant data with mem_we=1 and the exact data/strobes; dm_valid fires before the fetch grant; then mem_addr=0x104.
- flush asserted one cycle into a fetch of 0x108 (ack delayed 3 cycles) → no if_valid for 0x108; next fetch 0x200 is granted after ack and returns its data.
- rst asserted while GNT_DM is waiting for ack → next cycle mem_req=0, busy=0, all valids 0; a subsequent ack is ignored; a new fetch completes normally.
- mem_ack tied 1, alternating dm load/fetch requests → each completes with 2-cycle latency, valids never overlap.
- dm_req held for 6 transactions with if_req pending → with STARVE_GUARD_EN the fetch is granted after the 4th data grant; without it, after the 6th.
